video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing master for the 320x240 display path in the clk_video domain. Produces x_count/y_count/line_start for video_scanout.
//  Aligns hs/vs/de to its registered pixel_color and emits the Pocket video_* bus.
//  Also owns fb_base_addr: CPU buffer-swap requests cross in by toggle and commit only at frame boundary (tear-free).
// PARAMETERS
//  H_TOTAL 400 clocks per line; H_BPORCH 40 first active x; H_ACTIVE 320 active pixels
//  V_TOTAL 512 lines per frame (60 Hz at 12.288 MHz); V_BPORCH 16 first active y; V_ACTIVE 240 active lines
//  HS_X 3 x position of the hs pulse
//  PIX_LAT 1 scanout pixel latency (cycles) that sync/de outputs are delayed by
//  FB_RESET_ADDR 25'h0 fb_base_addr after reset
// PORTS
//  clk_video      in   1   video clock, 12.288 MHz
//  reset_n        in   1   asynchronous, active-low reset
//  x_count        out  10  horizontal counter, 0..H_TOTAL-1
//  y_count        out  10  vertical counter, 0..V_TOTAL-1
//  line_start     out  1   high in every cycle where x_count==0 (after first wrap)
//  vblank         out  1   y_count outside [V_BPORCH, V_BPORCH+V_ACTIVE)
//  pixel_in       in   24  RGB888 from scanout, valid PIX_LAT cycles after x/y
//  video_rgb      out  24  pixel_in when video_de, else 0
//  video_de       out  1   active-area enable, delayed PIX_LAT
//  video_hs       out  1   1-cycle pulse at x==HS_X, delayed PIX_LAT
//  video_vs       out  1   1-cycle pulse at x==0,y==0, delayed PIX_LAT
//  fb_next_addr   in   25  back-buffer address, CPU domain, quasi-static
//  swap_req_tgl   in   1   CPU-domain toggle: each edge requests one swap
//  swap_ack_tgl   out  1   toggles once per committed swap
//  fb_base_addr   out  25  front-buffer address to scanout
//  frame_count    out  16  frames since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: x=0, y=0, line_start=0, vblank=1, video_*=0, swap_ack_tgl=0.
//  Reset: fb_base_addr=FB_RESET_ADDR, frame_count=0, pending=0, sync flops 0.
//  Counters: x increments each clock; x==H_TOTAL-1 -> x=0, y+1; y==V_TOTAL-1 at x wrap -> y=0.
//  line_start is registered and set in the same edge that loads x=0. It is 0 on the first x=0 after reset release.
//  de_raw = x in [H_BPORCH,H_BPORCH+H_ACTIVE) and y in [V_BPORCH,V_BPORCH+V_ACTIVE). de/hs/vs pass through a PIX_LAT-deep shift register.
//  video_rgb is registered in parallel with the last delay stage and uses pixel_in sampled in that cycle.
//  All outputs are registered; none is combinational from inputs.
//  Swap CDC: swap_req_tgl -> 2-FF sync -> 3rd flop. req_edge = s2^s3. req_edge sets pending.
//  Multiple edges before commit merge into one swap and one ack toggle.
//  Frame boundary = cycle with x==H_TOTAL-1 and y==V_TOTAL-1.
//    At boundary, if pending|req_edge: fb_base_addr<=fb_next_addr, pending<=0, swap_ack_tgl flips.
//    frame_count increments at every boundary, swap or not.
//  req_edge in the boundary cycle is committed at that boundary, not the next.
//  fb_next_addr must stay stable from the CPU toggle until ack is seen. It is sampled directly; no data sync. This is a documented CPU-side rule.
//  fb_base_addr therefore changes only while y==0, i.e. well before scanout's first fetch at y=V_BPORCH-1.
//  Reset mid-frame: everything returns to reset values immediately. A pending swap is discarded.
//  Width: compare bounds as 10-bit constants; V_TOTAL<=1024, H_TOTAL<=1024 are enforced by an elaboration check.
// STRUCTURE
//  video_timing_pkg: H_/V_ defaults, HS_X, 25-bit SDRAM word-address width constant.
//    Scanout shares these parameters (package is single source of truth).
//  Sub-module sync_toggle (2-FF sync + edge flop, reset_n async). Reused for other CPU->video toggles.
//  Top holds counters, delay line, swap FSM.
//  Swap FSM states: IDLE (no pending) -> PENDING on req_edge. PENDING -> IDLE at boundary. Boundary+req_edge in IDLE commits directly.
// TESTING
//  1 Reset release, run 2 frames -> x wraps at 399, y wraps at 511; line_start count = 1023; first line_start at cycle 400; frame_count=2.
//  2 Active window -> video_de high for 320x240=76800 cycles per frame; first de at x=41,y=16 (PIX_LAT=1); pixel_in=24'hABCDEF passes only when de.
//  3 hs/vs -> vs single pulse per frame, one cycle after x=0,y=0; hs 512 pulses/frame at x==4.
//  4 Swap mid-frame: fb_next_addr=25'h12C00, toggle at y=100 -> fb_base_addr unchanged until boundary, then 25'h12C00 and ack flips once.
//  5 Swap edge coinciding with boundary (req_edge at x=399,y=511) -> commit that boundary. Two toggles in one frame -> one commit, ack flips once.
//  6 reset_n low at y=200 with swap pending -> fb_base_addr=FB_RESET_ADDR, no ack after release, counters restart at 0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared raster constants for the 320x240 video path. video_timing_gen and
//   video_scanout both take their defaults from here.
//   Also holds the SDRAM word-address width, the swap FSM state type and the
//   record carried down the sync/de delay line.
package video_timing_pkg;

  localparam int DEF_H_TOTAL  = 400;  // clocks per line
  localparam int DEF_H_BPORCH = 40;   // first active x
  localparam int DEF_H_ACTIVE = 320;  // active pixels per line
  localparam int DEF_V_TOTAL  = 512;  // lines per frame (60 Hz at 12.288 MHz)
  localparam int DEF_V_BPORCH = 16;   // first active y
  localparam int DEF_V_ACTIVE = 240;  // active lines per frame
  localparam int DEF_HS_X     = 3;    // x position of the hs pulse
  localparam int DEF_PIX_LAT  = 1;    // scanout pixel latency in clocks

  localparam int CNT_W = 10;          // x/y counter width
  localparam int FB_AW = 25;          // SDRAM word-address width

  localparam logic [FB_AW-1:0] DEF_FB_RESET_ADDR = '0;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/sync_toggle.sv
// sync_toggle
//   Brings a toggle-encoded request from another clock domain into clk.
//   Two synchronising flops followed by an edge-detect flop. o_edge is high
//   for exactly one clk cycle per toggle of i_tgl.
// Ports
//   clk      in  destination clock
//   reset_n  in  asynchronous active-low reset; all flops clear to 0
//   i_tgl    in  source-domain toggle
//   o_edge   out one-cycle pulse per source toggle
module sync_toggle (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tgl,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_tgl;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 ^ r_s3;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing master in the clk_video domain. Generates x/y counters for
//   scanout, delays de/hs/vs by the scanout pixel latency so they line up with
//   pixel_in, and owns the front-buffer address. CPU swap requests arrive as a
//   toggle and are committed only in the last cycle of a frame, so scanout
//   never sees the address change mid-frame.
// Ports
//   clk_video, reset_n        clock, asynchronous active-low reset
//   x_count, y_count          raster position
//   line_start                high while x_count==0 (not on the first line)
//   vblank                    y_count outside the active lines
//   pixel_in                  RGB888 from scanout, PIX_LAT clocks after x/y
//   video_rgb/de/hs/vs        Pocket video bus, all registered
//   fb_next_addr              back-buffer address, CPU domain, held stable
//                             from the request toggle until the ack toggle
//   swap_req_tgl/swap_ack_tgl swap request/acknowledge toggles
//   fb_base_addr              front-buffer address to scanout
//   frame_count               completed frames since reset, wraps
//   dbg_swap_state            swap FSM state
//
// Swap handshake: the CPU flips swap_req_tgl once per request; this block
// flips swap_ack_tgl once per committed swap. Requests that arrive before a
// commit merge into that commit and produce a single ack toggle.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int               H_TOTAL       = DEF_H_TOTAL,
  parameter int               H_BPORCH      = DEF_H_BPORCH,
  parameter int               H_ACTIVE      = DEF_H_ACTIVE,
  parameter int               V_TOTAL       = DEF_V_TOTAL,
  parameter int               V_BPORCH      = DEF_V_BPORCH,
  parameter int               V_ACTIVE      = DEF_V_ACTIVE,
  parameter int               HS_X          = DEF_HS_X,
  parameter int               PIX_LAT       = DEF_PIX_LAT,
  parameter logic [FB_AW-1:0] FB_RESET_ADDR = DEF_FB_RESET_ADDR
) (
  input  logic              clk_video,
  input  logic              reset_n,
  output logic [CNT_W-1:0]  x_count,
  output logic [CNT_W-1:0]  y_count,
  output logic              line_start,
  output logic              vblank,
  input  logic [23:0]       pixel_in,
  output logic [23:0]       video_rgb,
  output logic              video_de,
  output logic              video_hs,
  output logic              video_vs,
  input  logic [FB_AW-1:0]  fb_next_addr,
  input  logic              swap_req_tgl,
  output logic              swap_ack_tgl,
  output logic [FB_AW-1:0]  fb_base_addr,
  output logic [15:0]       frame_count,
  output swap_state_e       dbg_swap_state
);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_BPORCH + H_ACTIVE > H_TOTAL ||
      V_BPORCH + V_ACTIVE > V_TOTAL || HS_X >= H_TOTAL || PIX_LAT < 1) begin : g_bad_params
    $error("video_timing_gen: raster parameters out of range");
  end

  localparam logic [CNT_W-1:0] C_H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_H_ACT_BEG = CNT_W'(H_BPORCH);
  localparam logic [CNT_W-1:0] C_H_ACT_END = CNT_W'(H_BPORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_ACT_BEG = CNT_W'(V_BPORCH);
  localparam logic [CNT_W-1:0] C_V_ACT_END = CNT_W'(V_BPORCH + V_ACTIVE);
  localparam logic [CNT_W-1:0] C_HS_X      = CNT_W'(HS_X);

  // ---------------- raster counters ----------------
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_line_start;
  logic             r_vblank;
  logic             w_x_last;
  logic             w_y_last;
  logic             w_boundary;
  logic [CNT_W-1:0] w_x_next;
  logic [CNT_W-1:0] w_y_next;

  always_comb begin
    w_x_last   = (r_x == C_H_LAST);
    w_y_last   = (r_y == C_V_LAST);
    w_boundary = w_x_last & w_y_last;
    w_x_next   = w_x_last ? '0 : r_x + 1'b1;
    w_y_next   = r_y;
    if (w_x_last) w_y_next = w_y_last ? '0 : r_y + 1'b1;
  end

  // line_start and vblank are computed from the next position so they are
  // aligned with x_count/y_count rather than one cycle behind.
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_line_start <= 1'b0;
      r_vblank     <= 1'b1;
    end else begin
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_line_start <= w_x_last;
      r_vblank     <= !((w_y_next >= C_V_ACT_BEG) && (w_y_next < C_V_ACT_END));
    end
  end

  // ---------------- sync/de delay line ----------------
  sync_t       w_raw;
  sync_t       r_dly [PIX_LAT];
  logic        w_last_in_de;
  logic [23:0] r_rgb;

  always_comb begin
    w_raw.de = (r_x >= C_H_ACT_BEG) && (r_x < C_H_ACT_END) &&
               (r_y >= C_V_ACT_BEG) && (r_y < C_V_ACT_END);
    w_raw.hs = (r_x == C_HS_X);
    w_raw.vs = (r_x == '0) && (r_y == '0);
  end

  // rgb is registered alongside the last delay stage, so it is gated by the
  // de value entering that stage.
  if (PIX_LAT == 1) begin : g_lat1
    assign w_last_in_de = w_raw.de;
  end else begin : g_latn
    assign w_last_in_de = r_dly[PIX_LAT-2].de;
  end

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIX_LAT; i++) r_dly[i] <= '0;
      r_rgb <= '0;
    end else begin
      r_dly[0] <= w_raw;
      for (int i = 1; i < PIX_LAT; i++) r_dly[i] <= r_dly[i-1];
      r_rgb <= w_last_in_de ? pixel_in : '0;
    end
  end

  // ---------------- buffer swap ----------------
  logic              w_req_edge;
  swap_state_e       r_state;
  swap_state_e       w_state_next;
  logic              w_commit;
  logic [FB_AW-1:0]  r_fb_base;
  logic              r_ack;
  logic [15:0]       r_frame_count;

  sync_toggle u_swap_sync (
    .clk     (clk_video),
    .reset_n (reset_n),
    .i_tgl   (swap_req_tgl),
    .o_edge  (w_req_edge)
  );

  // A request edge landing exactly on the boundary cycle commits there
  // rather than waiting a whole frame.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    case (r_state)
      SWAP_IDLE: begin
        if (w_boundary && w_req_edge) w_commit = 1'b1;
        else if (w_req_edge)          w_state_next = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (w_boundary) begin
          w_commit     = 1'b1;
          w_state_next = SWAP_IDLE;
        end
      end
    endcase
  end

  // fb_next_addr is sampled without synchronisation: the CPU keeps it stable
  // from its request toggle until it observes the ack toggle.
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= SWAP_IDLE;
      r_fb_base     <= FB_RESET_ADDR;
      r_ack         <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_next;
      if (w_commit) r_fb_base <= fb_next_addr;
      r_ack         <= r_ack ^ w_commit;
      r_frame_count <= r_frame_count + 16'(w_boundary);
    end
  end

  assign x_count        = r_x;
  assign y_count        = r_y;
  assign line_start     = r_line_start;
  assign vblank         = r_vblank;
  assign video_de       = r_dly[PIX_LAT-1].de;
  assign video_hs       = r_dly[PIX_LAT-1].hs;
  assign video_vs       = r_dly[PIX_LAT-1].vs;
  assign video_rgb      = r_rgb;
  assign swap_ack_tgl   = r_ack;
  assign fb_base_addr   = r_fb_base;
  assign frame_count    = r_frame_count;
  assign dbg_swap_state = r_state;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Drives video_timing_gen with a reduced raster (40x24 clocks per frame) so
//   many frames fit in a short run. Expected outputs come from a reference
//   model written in terms of the elapsed cycle count t since reset release:
//   position is t mod line/frame length, delayed signals look at t-1, and
//   swaps are a list of request cycles committed at the first frame boundary
//   at least two cycles (synchroniser depth) after the request.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int HT    = 40;
  localparam int HB    = 4;
  localparam int HA    = 32;
  localparam int VT    = 24;
  localparam int VB    = 2;
  localparam int VA    = 16;
  localparam int HSX   = 3;
  localparam int PL    = 1;
  localparam int FRAME = HT * VT;
  localparam logic [FB_AW-1:0] FB_RST = 25'h0ABCD;

  // ---------------- clock / reset ----------------
  logic              clk_video = 1'b0;
  logic              reset_n   = 1'b0;
  logic [CNT_W-1:0]  x_count;
  logic [CNT_W-1:0]  y_count;
  logic              line_start;
  logic              vblank;
  logic [23:0]       pixel_in = '0;
  logic [23:0]       video_rgb;
  logic              video_de;
  logic              video_hs;
  logic              video_vs;
  logic [FB_AW-1:0]  fb_next_addr = '0;
  logic              swap_req_tgl = 1'b0;
  logic              swap_ack_tgl;
  logic [FB_AW-1:0]  fb_base_addr;
  logic [15:0]       frame_count;
  swap_state_e       dbg_swap_state;

  always #5 clk_video = ~clk_video;

  video_timing_gen #(
    .H_TOTAL(HT), .H_BPORCH(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_BPORCH(VB), .V_ACTIVE(VA),
    .HS_X(HSX), .PIX_LAT(PL), .FB_RESET_ADDR(FB_RST)
  ) dut (
    .clk_video      (clk_video),
    .reset_n        (reset_n),
    .x_count        (x_count),
    .y_count        (y_count),
    .line_start     (line_start),
    .vblank         (vblank),
    .pixel_in       (pixel_in),
    .video_rgb      (video_rgb),
    .video_de       (video_de),
    .video_hs       (video_hs),
    .video_vs       (video_vs),
    .fb_next_addr   (fb_next_addr),
    .swap_req_tgl   (swap_req_tgl),
    .swap_ack_tgl   (swap_ack_tgl),
    .fb_base_addr   (fb_base_addr),
    .frame_count    (frame_count),
    .dbg_swap_state (dbg_swap_state)
  );

  // ---------------- reference model ----------------
  int               n_cmp = 0;
  int               n_bad = 0;
  int               t = 0;
  int               req_q[$];
  logic [FB_AW-1:0] m_fb = FB_RST;
  logic             m_ack = 1'b0;
  int               last_tgl = -100;
  bit               rand_swaps = 1'b0;

  function automatic int fx(int c);
    return c % HT;
  endfunction

  function automatic int fy(int c);
    return (c / HT) % VT;
  endfunction

  function automatic bit in_active(int c);
    return (fx(c) >= HB) && (fx(c) < HB + HA) && (fy(c) >= VB) && (fy(c) < VB + VA);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    req_q    = {};
    m_fb     = FB_RST;
    m_ack    = 1'b0;
    last_tgl = -100;
  endtask

  // Account for the clock edge that ends cycle t.
  task automatic model_advance();
    if (fx(t) == HT - 1 && fy(t) == VT - 1 && req_q.size() > 0 && req_q[0] + 2 <= t) begin
      while (req_q.size() > 0 && req_q[0] + 2 <= t) void'(req_q.pop_front());
      m_fb  = fb_next_addr;
      m_ack = ~m_ack;
    end
    t++;
  endtask

  task automatic check_all();
    bit exp_de, exp_hs, exp_vs, exp_pend;
    exp_de   = (t > 0) && in_active(t - 1);
    exp_hs   = (t > 0) && (fx(t - 1) == HSX);
    exp_vs   = (t > 0) && (fx(t - 1) == 0) && (fy(t - 1) == 0);
    exp_pend = (req_q.size() > 0) && (req_q[0] + 2 <= t - 1);
    check_eq("x_count", x_count, fx(t));
    check_eq("y_count", y_count, fy(t));
    check_eq("line_start", line_start, (t >= HT) && (fx(t) == 0));
    check_eq("vblank", vblank, !((fy(t) >= VB) && (fy(t) < VB + VA)));
    check_eq("video_de", video_de, exp_de);
    check_eq("video_hs", video_hs, exp_hs);
    check_eq("video_vs", video_vs, exp_vs);
    check_eq("video_rgb", video_rgb, exp_de ? pixel_in : 24'h0);
    check_eq("fb_base_addr", fb_base_addr, m_fb);
    check_eq("swap_ack_tgl", swap_ack_tgl, m_ack);
    check_eq("frame_count", frame_count, (t / FRAME) & 16'hFFFF);
    check_eq("swap_pending", dbg_swap_state == SWAP_PENDING, exp_pend);
  endtask

  // ---------------- driver tasks ----------------
  task automatic toggle_req();
    swap_req_tgl = ~swap_req_tgl;
    req_q.push_back(t);
    last_tgl = t;
  endtask

  task automatic drive_inputs();
    pixel_in = 24'($urandom());
    if (rand_swaps && (t - last_tgl > 4)) begin
      if (req_q.size() == 0) begin
        if ($urandom_range(0, 249) == 0) begin
          fb_next_addr = 25'($urandom());
          toggle_req();
        end
      end else if ($urandom_range(0, 399) == 0) begin
        toggle_req();
      end
    end
  endtask

  task automatic step();
    @(posedge clk_video);
    model_advance();
    @(negedge clk_video);
    check_all();
    drive_inputs();
  endtask

  // Advance until the frame position t mod FRAME equals target.
  task automatic run_to(input int target);
    int n;
    n = 0;
    step();
    while ((t % FRAME) != target && n < FRAME + 2) begin
      step();
      n++;
    end
    check_eq("run_to_reached", (t % FRAME) == target, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk_video);
    reset_n      = 1'b0;
    swap_req_tgl = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk_video);
    check_all();
    reset_n = 1'b1;
    drive_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Reset release and free-running raster with random pixels and swaps.
    rand_swaps = 1'b1;
    repeat (3 * FRAME) step();
    rand_swaps = 1'b0;
    run_to(0);
    run_to(0);

    // Swap requested mid-frame commits at the next boundary.
    run_to(10 * HT);
    fb_next_addr = 25'h12C00;
    toggle_req();
    run_to(1);
    check_eq("mid_frame_swap_fb", fb_base_addr, 25'h12C00);

    // Request edge lands exactly on the boundary cycle.
    run_to(FRAME - 3);
    fb_next_addr = 25'h01F00;
    toggle_req();
    run_to(1);
    check_eq("boundary_swap_fb", fb_base_addr, 25'h01F00);

    // Two toggles in one frame merge into one commit.
    run_to(3 * HT);
    fb_next_addr = 25'h04B00;
    toggle_req();
    run_to(8 * HT);
    toggle_req();
    run_to(1);
    check_eq("merged_swap_fb", fb_base_addr, 25'h04B00);

    // Reset mid-frame discards a pending swap.
    run_to(3 * HT);
    fb_next_addr = 25'h07777;
    toggle_req();
    run_to(20 * HT);
    do_reset();
    run_to(1);
    check_eq("reset_discard_fb", fb_base_addr, FB_RST);

    rand_swaps = 1'b1;
    repeat (2 * FRAME) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
